// File: rtl/addsub_pkg.sv
// Shared definitions for the addsub_pipe execution unit: op encodings,
// default geometry and saturation constants.
package addsub_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_LANE_W = 4;
    localparam int unsigned MAX_W      = 64;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PADD = 2'b10,
        OP_PSUB = 2'b11
    } op_e;

    // Most positive w-bit two's complement value, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_pos(input int unsigned w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r[i] = (i + 1 < w);
        end
        return r;
    endfunction

    // Most negative w-bit two's complement value, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_neg(input int unsigned w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            r[i] = (i + 1 == w);
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Issue/writeback bundle for addsub_pipe: operand handshake in, result
// handshake and flags out.
interface addsub_pipe_if
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_v, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_v, busy
    );
endinterface

// File: rtl/addsub_lane.sv
// One LANE_W-bit carry-lookahead block with carry-out and signed overflow
// of its own top bit.
module addsub_lane #(
    parameter int unsigned LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    output logic [LANE_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);
    logic [LANE_W-1:0] g;
    logic [LANE_W-1:0] p;
    logic [LANE_W:0]   c;
    logic              prod;
    logic              acc;

    // Each carry is a flat sum of products of g/p/cin, so no carry depends on another.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        prod = 1'b1;
        acc  = 1'b0;
        for (int unsigned i = 0; i < LANE_W; i++) begin
            prod = 1'b1;
            acc  = g[i];
            for (int unsigned k = i; k > 0; k--) begin
                prod = prod & p[k];
                acc  = acc | (prod & g[k-1]);
            end
            prod     = prod & p[0];
            acc      = acc | (prod & cin);
            c[i+1]   = acc;
        end
    end

    assign sum  = p ^ c[LANE_W-1:0];
    assign cout = c[LANE_W];
    assign ovf  = (a[LANE_W-1] == b[LANE_W-1]) & (sum[LANE_W-1] != a[LANE_W-1]);

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/sub unit with full-width and lane-wise packed modes.
// Define ADDSUB_SAT_EN to saturate overflowing units instead of wrapping.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned LANE_W = DEF_LANE_W
) (
    input logic         clk,
    input logic         rst_n,
    addsub_pipe_if.slave bus
);
    localparam int unsigned LANES = WIDTH / LANE_W;

    generate
        if ((WIDTH % LANE_W) != 0 || WIDTH > MAX_W || LANE_W < 2) begin : g_bad_geometry
            $error("addsub_pipe: WIDTH must be a multiple of LANE_W (LANE_W >= 2, WIDTH <= 64)");
        end
    endgenerate

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    logic             s2_n;
    logic             s2_z;
    logic             s2_v;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv       = !s2_valid | bus.out_ready;
    assign s1_adv       = !s1_valid | s2_adv;
    assign accept       = bus.in_valid & s1_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
                s1_a  <= bus.a;
                s1_b  <= bus.b;
                s1_op <= op_e'(bus.op);
            end
        end
    end

    logic              sub;
    logic              packed_mode;
    logic [WIDTH-1:0]  b_eff;
    logic [LANES-1:0]  lane_cin;
    logic [LANES-1:0]  lane_cout;
    logic [LANES-1:0]  lane_ovf;
    logic [WIDTH-1:0]  raw_sum;

    assign sub         = (s1_op == OP_SUB)  | (s1_op == OP_PSUB);
    assign packed_mode = (s1_op == OP_PADD) | (s1_op == OP_PSUB);
    assign b_eff       = sub ? ~s1_b : s1_b;

    // Packed modes re-inject the subtract bit at every lane instead of chaining.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            if (l == 0) begin : g_first
                assign lane_cin[l] = sub;
            end else begin : g_rest
                assign lane_cin[l] = packed_mode ? sub : lane_cout[l-1];
            end

            addsub_lane #(.LANE_W(LANE_W)) u_lane (
                .a   (s1_a[l*LANE_W +: LANE_W]),
                .b   (b_eff[l*LANE_W +: LANE_W]),
                .cin (lane_cin[l]),
                .sum (raw_sum[l*LANE_W +: LANE_W]),
                .cout(lane_cout[l]),
                .ovf (lane_ovf[l])
            );
        end
    endgenerate

    logic [WIDTH-1:0] fin_res;
    logic             fin_v;

    always_comb begin
        fin_res = raw_sum;
        fin_v   = packed_mode ? |lane_ovf : lane_ovf[LANES-1];
`ifdef ADDSUB_SAT_EN
        // The A sign of an overflowing unit gives the overflow direction.
        if (packed_mode) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (lane_ovf[l]) begin
                    fin_res[l*LANE_W +: LANE_W] = s1_a[l*LANE_W + LANE_W - 1]
                        ? LANE_W'(sat_neg(LANE_W)) : LANE_W'(sat_pos(LANE_W));
                end
            end
        end else if (lane_ovf[LANES-1]) begin
            fin_res = s1_a[WIDTH-1] ? WIDTH'(sat_neg(WIDTH)) : WIDTH'(sat_pos(WIDTH));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_n     <= 1'b0;
            s2_z     <= 1'b0;
            s2_v     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= fin_res;
                s2_n   <= fin_res[WIDTH-1];
                s2_z   <= (fin_res == '0);
                s2_v   <= fin_v;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_res;
    assign bus.flag_n    = s2_n;
    assign bus.flag_z    = s2_z;
    assign bus.flag_v    = s2_v;
    assign bus.busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, LANE_W=4); honours ADDSUB_SAT_EN
// so the same bench covers the wrapping and saturating builds.
module tb_addsub_pipe;
    import addsub_pkg::*;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;

    addsub_pipe_if #(.WIDTH(16)) bus ();

    addsub_pipe #(.WIDTH(16), .LANE_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    endtask

    // Reference: signed integer arithmetic on the whole word or on each 4-bit lane.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        int          r;
        logic [3:0]  la;
        logic [3:0]  lb;
        e.v   = 1'b0;
        e.res = '0;
        if (o[1] == 1'b0) begin
            r = (o == 2'b01) ? int'($signed(x)) - int'($signed(y))
                             : int'($signed(x)) + int'($signed(y));
            e.res = r[15:0];
            if (r > 32767) begin
                e.v = 1'b1;
                if (SAT) e.res = 16'h7FFF;
            end else if (r < -32768) begin
                e.v = 1'b1;
                if (SAT) e.res = 16'h8000;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                la = x[4*l +: 4];
                lb = y[4*l +: 4];
                r  = (o == 2'b11) ? int'($signed(la)) - int'($signed(lb))
                                  : int'($signed(la)) + int'($signed(lb));
                e.res[4*l +: 4] = r[3:0];
                if (r > 7) begin
                    e.v = 1'b1;
                    if (SAT) e.res[4*l +: 4] = 4'h7;
                end else if (r < -8) begin
                    e.v = 1'b1;
                    if (SAT) e.res[4*l +: 4] = 4'h8;
                end
            end
        end
        return e;
    endfunction

    // One clock of stimulus; samples mid-cycle and scores any delivery.
    task automatic cycle(input logic v, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.op        = o;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = ordy;
        #1;
        acc = v & bus.in_ready;
        check("busy", {31'b0, bus.busy}, {31'b0, exp_q.size() != 0});
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {16'b0, bus.result}, {16'b0, e.res});
                check("flags_nzv", {29'b0, bus.flag_n, bus.flag_z, bus.flag_v},
                      {29'b0, e.res[15], e.res == 16'h0, e.v});
            end
        end
        if (acc) exp_q.push_back(model(o, x, y));
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        check(tag, exp_q.size(), 0);
    endtask

    logic [15:0] dir_a [9] = '{16'd20000, 16'd20000, 16'd20000, 16'h8000, 16'h0000,
                               16'h7654,  16'h0000,  16'h1234,  16'hFFFF};
    logic [15:0] dir_b [9] = '{16'd10000, 16'd20000, 16'd20000, 16'h0001, 16'h8000,
                               16'h1111,  16'h1111,  16'h1234,  16'h0001};
    logic [1:0]  dir_op[9] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB,
                               OP_PADD, OP_PSUB, OP_SUB, OP_ADD};
    logic [15:0] edge_val [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                                  16'hFFFF, 16'h8888, 16'h7777, 16'h8001};

    initial begin
        logic        acc;
        logic [15:0] ra, rb;
        logic [1:0]  ro;
        exp_t        e1;
        int          stale;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_result", {16'b0, bus.result}, 32'd0);
        check("rst_flags", {29'b0, bus.flag_n, bus.flag_z, bus.flag_v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Latency: accept in cycle c, out_valid visible in cycle c+2.
        cycle(1'b1, OP_ADD, 16'd20000, 16'd10000, 1'b1, acc);
        check("lat_accept", {31'b0, acc}, 32'd1);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        check("lat_c1_valid", {31'b0, bus.out_valid}, 32'd0);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        check("lat_c2_valid", {31'b0, bus.out_valid}, 32'd1);
        drain("drain_lat");

        // Directed boundary vectors back to back at full throughput.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, dir_op[i], dir_a[i], dir_b[i], 1'b1, acc);
            check("dir_accept", {31'b0, acc}, 32'd1);
        end
        drain("drain_dir");

        // Backpressure: two ops fill the pipe, the third is refused.
        cycle(1'b1, OP_ADD, 16'd20000, 16'd20000, 1'b0, acc);
        check("bp_acc1", {31'b0, acc}, 32'd1);
        cycle(1'b1, OP_SUB, 16'h8000, 16'h0001, 1'b0, acc);
        check("bp_acc2", {31'b0, acc}, 32'd1);
        e1 = model(OP_ADD, 16'd20000, 16'd20000);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, OP_PADD, 16'h7654, 16'h1111, 1'b0, acc);
            check("bp_acc3_blocked", {31'b0, acc}, 32'd0);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("bp_hold_result", {16'b0, bus.result}, {16'b0, e1.res});
            check("bp_hold_v", {31'b0, bus.flag_v}, {31'b0, e1.v});
        end
        cycle(1'b1, OP_PADD, 16'h7654, 16'h1111, 1'b1, acc);
        check("bp_acc3", {31'b0, acc}, 32'd1);
        check("bp_deliver1", {31'b0, bus.out_valid}, 32'd1);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        check("bp_deliver2", {31'b0, bus.out_valid}, 32'd1);
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        check("bp_deliver3", {31'b0, bus.out_valid}, 32'd1);
        check("bp_empty", exp_q.size(), 0);

        // Randomised traffic with random stalls and boundary-biased operands.
        for (int i = 0; i < 400; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? edge_val[$urandom_range(0, 7)] : 16'($urandom());
            rb = ($urandom_range(0, 3) == 0) ? edge_val[$urandom_range(0, 7)] : 16'($urandom());
            cycle($urandom_range(0, 3) != 0, ro, ra, rb, $urandom_range(0, 3) != 0, acc);
        end
        drain("drain_rand");

        // Asynchronous reset with two ops in flight.
        cycle(1'b1, OP_ADD, 16'd20000, 16'd10000, 1'b0, acc);
        cycle(1'b1, OP_SUB, 16'h0000, 16'h8000, 1'b0, acc);
        @(posedge clk);
        #2;
        check("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_busy", {31'b0, bus.busy}, 32'd0);
        check("arst_result", {16'b0, bus.result}, 32'd0);
        check("arst_flags", {29'b0, bus.flag_n, bus.flag_z, bus.flag_v}, 32'd0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
            if (bus.out_valid) stale++;
        end
        check("no_stale", stale, 0);

        // Pipe still works after reset.
        cycle(1'b1, OP_SUB, 16'h1234, 16'h1234, 1'b1, acc);
        check("post_rst_accept", {31'b0, acc}, 32'd1);
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
